// File: rtl/jtkcpu_useq.sv
// KCPU microcode sequencer: maps op categories to routines and walks an async ucode ROM.
// Optional feature macro JTKCPU_UCALL_EN builds the micro-call stack (call/ret with fault halt).
module jtkcpu_useq #(
  parameter int UCODE_AW    = 10,
  parameter int OPCAT_AW    = 6,
  parameter int UCODE_DW    = 32,
  parameter int STACK_DEPTH = 2,
  parameter int NMI_CAT     = 27,
  parameter int FIRQ_CAT    = 25,
  parameter int IRQ_CAT     = 26
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cen,
  input  logic [OPCAT_AW-1:0]   opcat,
  input  logic [UCODE_DW-1:0]   udata,
  input  logic                  mem_busy,
  input  logic                  alu_busy,
  input  logic                  branch,
  input  logic                  nmi,
  input  logic                  firq,
  input  logic                  irq,
  input  logic                  fmask,
  input  logic                  imask,
  output logic [UCODE_AW-1:0]   uaddr,
  output logic [UCODE_DW-9:0]   ctrl,
  output logic                  ctrl_en,
  output logic                  int_ack,
  output logic [1:0]            int_src,
  output logic                  halted
);
  localparam int RL_W = UCODE_AW - OPCAT_AW;
  localparam logic [OPCAT_AW-1:0] NMI_C  = OPCAT_AW'(NMI_CAT);
  localparam logic [OPCAT_AW-1:0] FIRQ_C = OPCAT_AW'(FIRQ_CAT);
  localparam logic [OPCAT_AW-1:0] IRQ_C  = OPCAT_AW'(IRQ_CAT);

  if (STACK_DEPTH < 1 || STACK_DEPTH > 4) begin : g_bad_depth
    $error("jtkcpu_useq: STACK_DEPTH must be 1..4");
  end

  function automatic logic [UCODE_AW-1:0] cat_addr(input logic [OPCAT_AW-1:0] cat);
    return {cat, {RL_W{1'b0}}};
  endfunction

  logic                 f_ni, f_call, f_ret, f_wmem, f_walu, f_bcc;
  logic                 stall;
  logic [OPCAT_AW-1:0]  target;
  logic [UCODE_AW-1:0]  uaddr_inc, next_uaddr;
  logic                 take_nmi, take_firq, take_irq, entry, illegal, fault;
  logic                 nmi_pend, nmi_prev;
  logic                 unused_rsvd;

  assign f_ni        = udata[0];
  assign f_call      = udata[1];
  assign f_ret       = udata[2];
  assign f_wmem      = udata[3];
  assign f_walu      = udata[4];
  assign f_bcc       = udata[5];
  assign unused_rsvd = ^udata[7:6];
  assign target      = udata[UCODE_DW-1 -: OPCAT_AW];
  assign uaddr_inc   = uaddr + UCODE_AW'(1);

  assign stall   = (f_wmem & mem_busy) | (f_walu & alu_busy);
  assign ctrl_en = cen & ~stall & ~halted;
  assign ctrl    = ctrl_en ? udata[UCODE_DW-1:8] : '0;
  assign entry   = take_nmi | take_firq | take_irq;

`ifdef JTKCPU_UCALL_EN
  localparam int SP_W = $clog2(STACK_DEPTH + 1);
  logic [UCODE_AW-1:0] stack [STACK_DEPTH];
  logic [SP_W-1:0]     sp;
  logic [UCODE_AW-1:0] pop_addr;
  logic                push, pop;

  always_comb begin
    pop_addr = '0;
    for (int i = 0; i < STACK_DEPTH; i++)
      if (sp == SP_W'(i + 1)) pop_addr = stack[i];
  end
`endif

  // Next-address decision for the row currently presented by the ROM
  always_comb begin
    next_uaddr = uaddr_inc;
    take_nmi   = 1'b0;
    take_firq  = 1'b0;
    take_irq   = 1'b0;
    illegal    = 1'b0;
    fault      = 1'b0;
`ifdef JTKCPU_UCALL_EN
    push       = 1'b0;
    pop        = 1'b0;
`endif
    if (f_ni) begin
      if (nmi_pend) begin
        take_nmi   = 1'b1;
        next_uaddr = cat_addr(NMI_C);
      end else if (firq & ~fmask) begin
        take_firq  = 1'b1;
        next_uaddr = cat_addr(FIRQ_C);
      end else if (irq & ~imask) begin
        take_irq   = 1'b1;
        next_uaddr = cat_addr(IRQ_C);
      end else if (&opcat) begin
        illegal    = 1'b1;
        next_uaddr = uaddr;
      end else begin
        next_uaddr = cat_addr(opcat);
      end
    end else if (f_ret) begin
`ifdef JTKCPU_UCALL_EN
      if (sp == '0) begin
        fault      = 1'b1;
        next_uaddr = uaddr;
      end else begin
        pop        = 1'b1;
        next_uaddr = pop_addr;
      end
`endif
    end else if (f_call) begin
`ifdef JTKCPU_UCALL_EN
      if (sp == SP_W'(STACK_DEPTH)) begin
        fault      = 1'b1;
        next_uaddr = uaddr;
      end else begin
        push       = 1'b1;
        next_uaddr = cat_addr(target);
      end
`else
      next_uaddr = cat_addr(target);
`endif
    end else if (f_bcc && branch) begin
      next_uaddr = cat_addr(target);
    end
  end

  // Control state: address, halt, interrupt bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      uaddr    <= '0;
      halted   <= 1'b0;
      nmi_pend <= 1'b0;
      nmi_prev <= 1'b0;
      int_ack  <= 1'b0;
      int_src  <= 2'b00;
`ifdef JTKCPU_UCALL_EN
      sp       <= '0;
`endif
    end else begin
      int_ack <= ctrl_en & entry;
      // Edge detection keeps running during stalls; a fresh edge wins over the clear
      if (cen) begin
        nmi_prev <= nmi;
        nmi_pend <= (nmi_pend & ~(ctrl_en & take_nmi)) | (nmi & ~nmi_prev);
      end
      if (ctrl_en) begin
        uaddr <= next_uaddr;
        if (illegal | fault) halted <= 1'b1;
        if (take_nmi)       int_src <= 2'b01;
        else if (take_firq) int_src <= 2'b10;
        else if (take_irq)  int_src <= 2'b11;
`ifdef JTKCPU_UCALL_EN
        if (push)     sp <= sp + SP_W'(1);
        else if (pop) sp <= sp - SP_W'(1);
`endif
      end
    end
  end

`ifdef JTKCPU_UCALL_EN
  // Return-address storage
  always_ff @(posedge clk) begin
    if (ctrl_en && push)
      for (int i = 0; i < STACK_DEPTH; i++)
        if (sp == SP_W'(i)) stack[i] <= uaddr_inc;
  end
`endif

endmodule

// File: tb/tb_jtkcpu_useq.sv
// Bench for jtkcpu_useq: directed scenarios plus randomized run against a behavioural model.
module tb_jtkcpu_useq;
  localparam int AW = 10, CW = 6, DW = 32, SD = 2;
  localparam int RL = 1 << (AW - CW);
  localparam logic [7:0] NI = 8'h01, CALL = 8'h02, RET = 8'h04, WMEM = 8'h08, WALU = 8'h10, BCC = 8'h20;

  logic clk = 1'b0;
  logic rst, cen, mem_busy, alu_busy, branch, nmi, firq, irq, fmask, imask;
  logic [CW-1:0] opcat;
  logic [DW-1:0] udata;
  logic [AW-1:0] uaddr;
  logic [DW-9:0] ctrl;
  logic ctrl_en, int_ack, halted;
  logic [1:0] int_src;
  logic [DW-1:0] rom [1<<AW];
  int checks = 0, errors = 0;

  assign udata = rom[uaddr];
  always #5 clk = ~clk;

  jtkcpu_useq #(.UCODE_AW(AW), .OPCAT_AW(CW), .UCODE_DW(DW), .STACK_DEPTH(SD),
                .NMI_CAT(27), .FIRQ_CAT(25), .IRQ_CAT(26)) dut (
    .clk(clk), .rst(rst), .cen(cen), .opcat(opcat), .udata(udata),
    .mem_busy(mem_busy), .alu_busy(alu_busy), .branch(branch),
    .nmi(nmi), .firq(firq), .irq(irq), .fmask(fmask), .imask(imask),
    .uaddr(uaddr), .ctrl(ctrl), .ctrl_en(ctrl_en), .int_ack(int_ack),
    .int_src(int_src), .halted(halted));

  function automatic logic [DW-1:0] row(input int tgt, input logic [7:0] seq, input logic [17:0] mid);
    logic [CW-1:0] t;
    t = CW'(tgt);
    return {t, mid, seq};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; cen = 1; mem_busy = 0; alu_busy = 0; branch = 0;
    nmi = 0; firq = 0; irq = 0; fmask = 0; imask = 0; opcat = '0;
  endtask

  task automatic clear_rom();
    for (int a = 0; a < (1 << AW); a++) rom[a] = '0;
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    idle(); clear_rom();
    rom[0] = row(0, NI, 18'h0);
    opcat = 6'd5;
    rst = 1;
    tick(); tick();
    checks++; if (uaddr !== 10'h000) begin errors++; $display("FAIL reset_uaddr: got %h want 000", uaddr); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
    checks++; if (int_ack !== 1'b0 || int_src !== 2'b00) begin errors++; $display("FAIL reset_int: got ack=%b src=%b want 0/00", int_ack, int_src); end
    rst = 0;
    tick();
    checks++; if (uaddr !== 10'h050) begin errors++; $display("FAIL reset_first_ni: got %h want 050", uaddr); end
  endtask

  task automatic test_stall();
    idle(); clear_rom();
    rom[0] = row(0, NI, 18'h0);
    opcat = 6'd5;
    do_reset(); tick();
    rom[10'h050] = row(2, WMEM, 18'h2A5A5);
    rom[10'h051] = row(0, WALU, 18'h01234);
    mem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (ctrl_en !== 1'b0 || ctrl !== '0) begin errors++; $display("FAIL stall_ctrl_en: cyc %0d got en=%b ctrl=%h want 0/0", i, ctrl_en, ctrl); end
      tick();
      checks++; if (uaddr !== 10'h050) begin errors++; $display("FAIL stall_hold: cyc %0d got %h want 050", i, uaddr); end
    end
    mem_busy = 0;
    #1;
    checks++; if (ctrl_en !== 1'b1 || ctrl !== 24'h0AA5A5) begin errors++; $display("FAIL stall_release: got en=%b ctrl=%h want 1/0aa5a5", ctrl_en, ctrl); end
    tick();
    checks++; if (uaddr !== 10'h051) begin errors++; $display("FAIL stall_advance: got %h want 051", uaddr); end
    alu_busy = 1;
    tick();
    checks++; if (uaddr !== 10'h051) begin errors++; $display("FAIL alu_stall: got %h want 051", uaddr); end
    alu_busy = 0; cen = 0;
    #1;
    checks++; if (ctrl_en !== 1'b0) begin errors++; $display("FAIL cen_low_en: got %b want 0", ctrl_en); end
    tick();
    checks++; if (uaddr !== 10'h051) begin errors++; $display("FAIL cen_low_hold: got %h want 051", uaddr); end
    cen = 1;
    tick();
    checks++; if (uaddr !== 10'h052) begin errors++; $display("FAIL cen_resume: got %h want 052", uaddr); end
  endtask

  task automatic test_interrupts();
    idle(); clear_rom();
    rom[1] = row(0, NI, 18'h0);
    do_reset();
    nmi = 1;
    tick();
    checks++; if (uaddr !== 10'h001 || int_ack !== 1'b0) begin errors++; $display("FAIL int_pre: got %h ack=%b want 001/0", uaddr, int_ack); end
    firq = 1; irq = 1;
    tick();
    checks++; if (uaddr !== 10'h1B0 || int_ack !== 1'b1 || int_src !== 2'b01) begin errors++; $display("FAIL int_nmi: got %h ack=%b src=%b want 1b0/1/01", uaddr, int_ack, int_src); end
    rom[10'h1B0] = row(0, NI, 18'h0);
    tick();
    checks++; if (uaddr !== 10'h190 || int_ack !== 1'b1 || int_src !== 2'b10) begin errors++; $display("FAIL int_firq: got %h ack=%b src=%b want 190/1/10", uaddr, int_ack, int_src); end
    tick();
    checks++; if (uaddr !== 10'h191 || int_ack !== 1'b0 || int_src !== 2'b10) begin errors++; $display("FAIL int_midroutine: got %h ack=%b src=%b want 191/0/10", uaddr, int_ack, int_src); end
    rom[10'h191] = row(0, NI, 18'h0);
    fmask = 1;
    tick();
    checks++; if (uaddr !== 10'h1A0 || int_ack !== 1'b1 || int_src !== 2'b11) begin errors++; $display("FAIL int_irq: got %h ack=%b src=%b want 1a0/1/11", uaddr, int_ack, int_src); end
    rom[10'h1A0] = row(0, NI, 18'h0);
    imask = 1; opcat = 6'd7;
    tick();
    checks++; if (uaddr !== 10'h070 || int_ack !== 1'b0 || int_src !== 2'b11) begin errors++; $display("FAIL int_masked: got %h ack=%b src=%b want 070/0/11", uaddr, int_ack, int_src); end
  endtask

  task automatic test_call();
    idle(); clear_rom();
    rom[0] = row(0, NI, 18'h0);
    opcat = 6'd5;
    do_reset(); tick(); tick(); tick();
    checks++; if (uaddr !== 10'h052) begin errors++; $display("FAIL call_setup: got %h want 052", uaddr); end
    rom[10'h052] = row(3, CALL, 18'h0);
    rom[10'h030] = row(0, RET, 18'h0);
    tick();
    checks++; if (uaddr !== 10'h030) begin errors++; $display("FAIL call_jump: got %h want 030", uaddr); end
    tick();
`ifdef JTKCPU_UCALL_EN
    checks++; if (uaddr !== 10'h053) begin errors++; $display("FAIL ret_pop: got %h want 053", uaddr); end
    rom[10'h053] = row(4, CALL, 18'h0);
    rom[10'h040] = row(8, CALL, 18'h0);
    rom[10'h080] = row(9, CALL, 18'h0);
    tick(); tick(); tick();
    checks++; if (halted !== 1'b1 || uaddr !== 10'h080) begin errors++; $display("FAIL call_overflow: got halted=%b %h want 1/080", halted, uaddr); end
    tick();
    checks++; if (uaddr !== 10'h080) begin errors++; $display("FAIL overflow_frozen: got %h want 080", uaddr); end
    rom[0] = row(0, RET, 18'h0);
    do_reset(); tick();
    checks++; if (halted !== 1'b1 || uaddr !== 10'h000) begin errors++; $display("FAIL ret_underflow: got halted=%b %h want 1/000", halted, uaddr); end
`else
    checks++; if (uaddr !== 10'h031) begin errors++; $display("FAIL ret_plain: got %h want 031", uaddr); end
    rom[0] = row(0, RET, 18'h0);
    do_reset(); tick();
    checks++; if (halted !== 1'b0 || uaddr !== 10'h001) begin errors++; $display("FAIL ret_no_fault: got halted=%b %h want 0/001", halted, uaddr); end
`endif
  endtask

  task automatic test_bcc();
    idle(); clear_rom();
    rom[0] = row(0, NI, 18'h0);
    opcat = 6'd6;
    do_reset(); tick();
    rom[10'h060] = row(10, BCC, 18'h0);
    rom[10'h061] = row(11, BCC, 18'h0);
    rom[10'h0B0] = row(63, BCC, 18'h0);
    tick();
    checks++; if (uaddr !== 10'h061) begin errors++; $display("FAIL bcc_not_taken: got %h want 061", uaddr); end
    branch = 1;
    tick();
    checks++; if (uaddr !== 10'h0B0) begin errors++; $display("FAIL bcc_taken: got %h want 0b0", uaddr); end
    tick();
    branch = 0;
    for (int i = 0; i < 15; i++) tick();
    checks++; if (uaddr !== 10'h3FF) begin errors++; $display("FAIL wrap_pre: got %h want 3ff", uaddr); end
    tick();
    checks++; if (uaddr !== 10'h000) begin errors++; $display("FAIL wrap: got %h want 000", uaddr); end
  endtask

  task automatic test_halt();
    idle(); clear_rom();
    rom[0] = row(0, NI, 18'h0);
    opcat = 6'h3F;
    do_reset(); tick();
    checks++; if (halted !== 1'b1 || uaddr !== 10'h000) begin errors++; $display("FAIL illegal_halt: got halted=%b %h want 1/000", halted, uaddr); end
    #1;
    checks++; if (ctrl_en !== 1'b0) begin errors++; $display("FAIL halted_ctrl_en: got %b want 0", ctrl_en); end
    irq = 1;
    tick();
    checks++; if (uaddr !== 10'h000 || int_ack !== 1'b0 || halted !== 1'b1) begin errors++; $display("FAIL halted_irq: got %h ack=%b halted=%b want 000/0/1", uaddr, int_ack, halted); end
    irq = 0; rst = 1;
    tick();
    checks++; if (halted !== 1'b0 || uaddr !== 10'h000) begin errors++; $display("FAIL halt_clear: got halted=%b %h want 0/000", halted, uaddr); end
    rst = 0; opcat = 6'd5;
    rom[10'h050] = row(0, WMEM, 18'h0);
    tick();
    checks++; if (uaddr !== 10'h050) begin errors++; $display("FAIL rst_mid_setup: got %h want 050", uaddr); end
    cen = 0; mem_busy = 1; rst = 1;
    tick();
    checks++; if (uaddr !== 10'h000) begin errors++; $display("FAIL rst_mid_routine: got %h want 000", uaddr); end
    idle();
  endtask

  task automatic test_random();
    int m_ua, m_src, nxt, tgt, halt_run;
    logic m_halt, m_pend, m_prev, m_ack, go, took_nmi;
    logic [DW-9:0] exp_ctrl;
    logic [DW-1:0] w;
    logic [7:0] s;
    int stk[$];
    for (int a = 0; a < (1 << AW); a++) begin
      s = '0;
      s[0] = ($urandom_range(3) == 0);
      s[1] = ($urandom_range(7) == 0);
      s[2] = ($urandom_range(11) == 0);
      s[3] = ($urandom_range(3) == 0);
      s[4] = ($urandom_range(3) == 0);
      s[5] = ($urandom_range(3) == 0);
      rom[a] = {24'($urandom()), s};
    end
    idle();
    do_reset();
    m_ua = 0; m_src = 0; m_halt = 0; m_pend = 0; m_prev = 0; m_ack = 0; halt_run = 0;
    stk.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst      = (halt_run > 3) || ($urandom_range(199) == 0);
      cen      = ($urandom_range(7) != 0);
      mem_busy = ($urandom_range(2) == 0);
      alu_busy = ($urandom_range(2) == 0);
      branch   = 1'($urandom_range(1));
      nmi      = ($urandom_range(4) == 0);
      firq     = ($urandom_range(9) == 0);
      irq      = ($urandom_range(5) == 0);
      fmask    = 1'($urandom_range(1));
      imask    = 1'($urandom_range(1));
      opcat    = ($urandom_range(40) == 0) ? 6'h3F : CW'($urandom_range(62));
      #1;
      w = rom[m_ua];
      go = cen && !((w[3] && mem_busy) || (w[4] && alu_busy)) && !m_halt;
      exp_ctrl = go ? w[DW-1:8] : '0;
      checks++; if (ctrl_en !== go) begin errors++; $display("FAIL rnd_ctrl_en: cyc %0d got %b want %b", cyc, ctrl_en, go); end
      checks++; if (ctrl !== exp_ctrl) begin errors++; $display("FAIL rnd_ctrl: cyc %0d got %h want %h", cyc, ctrl, exp_ctrl); end
      m_ack = 0;
      if (rst) begin
        m_ua = 0; m_src = 0; m_halt = 0; m_pend = 0; m_prev = 0;
        stk.delete();
      end else begin
        nxt = m_ua; took_nmi = 0;
        if (go) begin
          tgt = int'(w[DW-1 -: CW]);
          nxt = (m_ua + 1) % (1 << AW);
          if (w[0]) begin
            if (m_pend) begin nxt = 27 * RL; m_src = 1; m_ack = 1; took_nmi = 1; end
            else if (firq && !fmask) begin nxt = 25 * RL; m_src = 2; m_ack = 1; end
            else if (irq && !imask) begin nxt = 26 * RL; m_src = 3; m_ack = 1; end
            else if (opcat == 6'h3F) begin nxt = m_ua; m_halt = 1; end
            else nxt = int'(opcat) * RL;
          end else if (w[2]) begin
`ifdef JTKCPU_UCALL_EN
            if (stk.size() == 0) begin nxt = m_ua; m_halt = 1; end
            else nxt = stk.pop_back();
`endif
          end else if (w[1]) begin
`ifdef JTKCPU_UCALL_EN
            if (stk.size() == SD) begin nxt = m_ua; m_halt = 1; end
            else begin stk.push_back((m_ua + 1) % (1 << AW)); nxt = tgt * RL; end
`else
            nxt = tgt * RL;
`endif
          end else if (w[5] && branch) begin
            nxt = tgt * RL;
          end
        end
        if (cen) begin
          m_pend = (m_pend && !took_nmi) || (nmi && !m_prev);
          m_prev = nmi;
        end
        m_ua = nxt;
      end
      tick();
      checks++; if (uaddr !== AW'(m_ua)) begin errors++; $display("FAIL rnd_uaddr: cyc %0d got %h want %h", cyc, uaddr, AW'(m_ua)); end
      checks++; if (halted !== m_halt) begin errors++; $display("FAIL rnd_halted: cyc %0d got %b want %b", cyc, halted, m_halt); end
      checks++; if (int_ack !== m_ack) begin errors++; $display("FAIL rnd_int_ack: cyc %0d got %b want %b", cyc, int_ack, m_ack); end
      checks++; if (int_src !== 2'(m_src)) begin errors++; $display("FAIL rnd_int_src: cyc %0d got %b want %b", cyc, int_src, 2'(m_src)); end
      halt_run = m_halt ? halt_run + 1 : 0;
    end
    idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stall();
    test_interrupts();
    test_call();
    test_bcc();
    test_halt();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
